// File: rtl/frame_diff_scanner_pkg.sv
// Shared types and defaults for the image generator raster scanner.
package image_gen_pkg;

  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 12;
  localparam int CODE_W_DEF = 3;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    HEAD   = 3'd1,
    BODY   = 3'd2,
    APPLE  = 3'd3,
    BORDER = 3'd4
  } obj_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_DONE
  } scan_state_t;

  typedef enum logic [1:0] {
    MODE_DIFF,
    MODE_FULL,
    MODE_CLEAR
  } scan_mode_t;

endpackage

// File: rtl/frame_diff_scanner_if.sv
// Update-request channel from the scanner to the display command driver.
interface frame_diff_scanner_if #(
  parameter int X_W    = 4,
  parameter int Y_W    = 4,
  parameter int CODE_W = 3
);
  logic              upd_valid;
  logic              upd_ready;
  logic [X_W-1:0]    upd_x;
  logic [Y_W-1:0]    upd_y;
  logic [CODE_W-1:0] upd_code;

  modport master (
    output upd_valid, upd_x, upd_y, upd_code,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_x, upd_y, upd_code,
    output upd_ready
  );
endinterface

// File: rtl/frame_diff_scanner_mem.sv
// Previous-frame object codes: combinational read, one synchronous write port.
module prev_frame_mem
  import image_gen_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int CODE_W = CODE_W_DEF,
  parameter int X_W    = $clog2(GRID_W),
  parameter int Y_W    = $clog2(GRID_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [X_W-1:0]    wx_i,
  input  logic [Y_W-1:0]    wy_i,
  input  logic [CODE_W-1:0] wdata_i,
  input  logic [X_W-1:0]    rx_i,
  input  logic [Y_W-1:0]    ry_i,
  output logic [CODE_W-1:0] rdata_o
);

  logic [CODE_W-1:0] mem_q [GRID_H][GRID_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < GRID_H; r++) begin
        for (int unsigned c = 0; c < GRID_W; c++) begin
          mem_q[r][c] <= CODE_W'(EMPTY);
        end
      end
    end else if (we_i) begin
      mem_q[wy_i][wx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ry_i][rx_i];

endmodule

// File: rtl/frame_diff_scanner.sv
// Raster scanner: compares each cell against the previous frame and issues
// one update request per changed cell (diff / full redraw / clear modes).
module frame_diff_scanner
  import image_gen_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int CODE_W = CODE_W_DEF,
  parameter int X_W    = $clog2(GRID_W),
  parameter int Y_W    = $clog2(GRID_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 full_redraw,
  input  logic                 game_over,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  input  logic [CODE_W-1:0]    cell_code,
  output logic                 diff,
  frame_diff_scanner_if.master upd,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [CODE_W-1:0] EMPTY_CODE = CODE_W'(EMPTY);
  localparam logic [X_W-1:0]    X_LAST     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(GRID_H - 1);

  scan_state_t       state_q, state_d;
  scan_mode_t        mode_q, mode_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [X_W-1:0]    upd_x_q, upd_x_d;
  logic [Y_W-1:0]    upd_y_q, upd_y_d;
  logic [CODE_W-1:0] upd_code_q, upd_code_d;
  logic              init_pending_q, init_pending_d;

  logic [CODE_W-1:0] prev_code;
  logic [CODE_W-1:0] target;
  logic              issue;
  logic              prev_we;

  // Raster step shared by a quiet SCAN cell and an ISSUE handshake.
  logic              last_cell;
  scan_state_t       adv_state;
  logic [X_W-1:0]    adv_x;
  logic [Y_W-1:0]    adv_y;

  prev_frame_mem #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .CODE_W (CODE_W),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_prev (
    .clk     (clk),
    .rst     (rst),
    .we_i    (prev_we),
    .wx_i    (x_q),
    .wy_i    (y_q),
    .wdata_i (target),
    .rx_i    (x_q),
    .ry_i    (y_q),
    .rdata_o (prev_code)
  );

  always_comb begin
    last_cell = (x_q == X_LAST) && (y_q == Y_LAST);
    adv_state = ST_SCAN;
    adv_x     = x_q + X_W'(1);
    adv_y     = y_q;
    if (last_cell) begin
      adv_state = ST_DONE;
      adv_x     = '0;
      adv_y     = '0;
    end else if (x_q == X_LAST) begin
      adv_x = '0;
      adv_y = y_q + Y_W'(1);
    end
  end

  always_comb begin
    target = (mode_q == MODE_CLEAR) ? EMPTY_CODE : cell_code;
    issue  = 1'b0;
    unique case (mode_q)
      MODE_DIFF:  issue = (target != prev_code);
      MODE_FULL:  issue = 1'b1;
      MODE_CLEAR: issue = (prev_code != EMPTY_CODE);
      default:    issue = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    x_d            = x_q;
    y_d            = y_q;
    upd_x_d        = upd_x_q;
    upd_y_d        = upd_y_q;
    upd_code_d     = upd_code_q;
    init_pending_d = init_pending_q;
    prev_we        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          if (game_over)                         mode_d = MODE_CLEAR;
          else if (full_redraw || init_pending_q) mode_d = MODE_FULL;
          else                                   mode_d = MODE_DIFF;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (issue) begin
          upd_x_d    = x_q;
          upd_y_d    = y_q;
          upd_code_d = target;
          prev_we    = 1'b1;
          state_d    = ST_ISSUE;
        end else begin
          state_d = adv_state;
          x_d     = adv_x;
          y_d     = adv_y;
        end
      end
      ST_ISSUE: begin
        if (upd.upd_ready) begin
          state_d = adv_state;
          x_d     = adv_x;
          y_d     = adv_y;
        end
      end
      ST_DONE: begin
        init_pending_d = 1'b0;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_DIFF;
      x_q            <= '0;
      y_q            <= '0;
      upd_x_q        <= '0;
      upd_y_q        <= '0;
      upd_code_q     <= '0;
      init_pending_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      x_q            <= x_d;
      y_q            <= y_d;
      upd_x_q        <= upd_x_d;
      upd_y_q        <= upd_y_d;
      upd_code_q     <= upd_code_d;
      init_pending_q <= init_pending_d;
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign diff          = (state_q == ST_SCAN) && (cell_code != prev_code);
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = (state_q == ST_DONE);
  assign upd.upd_valid = (state_q == ST_ISSUE);
  assign upd.upd_x     = upd_x_q;
  assign upd.upd_y     = upd_y_q;
  assign upd.upd_code  = upd_code_q;

endmodule

// File: tb/tb_frame_diff_scanner.sv
// Randomized bench for frame_diff_scanner against a frame-level reference model.
module tb_frame_diff_scanner;

  localparam int GW = 16;
  localparam int GH = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start, full_redraw, game_over;
  logic [3:0] x, y;
  logic [2:0] cell_code;
  logic       diff, busy, frame_done;

  frame_diff_scanner_if #(.X_W(4), .Y_W(4), .CODE_W(3)) u_if ();

  frame_diff_scanner #(.GRID_W(GW), .GRID_H(GH), .CODE_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .full_redraw (full_redraw),
    .game_over   (game_over),
    .x           (x),
    .y           (y),
    .cell_code   (cell_code),
    .diff        (diff),
    .upd         (u_if.master),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  logic [2:0] map_m  [GH][GW];
  logic [2:0] prev_m [GH][GW];
  bit         init_m;

  assign cell_code = map_m[y][x];

  typedef struct { int ux; int uy; int code; } upd_t;
  upd_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int last_x, last_y, got_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level model: list every cell the scan must issue, in raster order.
  task automatic build_expect(input bit fr, input bit go);
    bit clear_m, full_m;
    int tgt;
    upd_t u;
    clear_m = go;
    full_m  = !go && (fr || init_m);
    exp_q.delete();
    for (int r = 0; r < GH; r++) begin
      for (int c = 0; c < GW; c++) begin
        tgt = clear_m ? 0 : int'(map_m[r][c]);
        if (full_m || (clear_m && prev_m[r][c] != 0) ||
            (!clear_m && !full_m && tgt != int'(prev_m[r][c]))) begin
          u.ux = c; u.uy = r; u.code = tgt;
          exp_q.push_back(u);
          prev_m[r][c] = 3'(tgt);
        end
      end
    end
    init_m = 1'b0;
  endtask

  task automatic run_frame(input bit fr, input bit go, input int delay,
                           input int pulse_at, input bit len_chk);
    int  n_exp, cyc, wait_cnt;
    bit  done, rdy, exp_d00;
    exp_d00 = (map_m[0][0] != prev_m[0][0]);
    build_expect(fr, go);
    n_exp = exp_q.size();
    got_cnt = 0; wait_cnt = 0; done = 0; last_x = -1; last_y = -1;
    @(negedge clk);
    frame_start = 1'b1; full_redraw = fr; game_over = go; u_if.upd_ready = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    full_redraw = 1'($urandom_range(0, 1));
    game_over   = 1'($urandom_range(0, 1));
    cyc = 1;
    chk("busy_start", busy, 1);
    chk("x_start", x, 0);
    chk("y_start", y, 0);
    chk("diff_00", diff, exp_d00);
    while (!done && cyc < 6000) begin
      if (frame_done) begin
        done = 1;
      end else begin
        frame_start = (cyc == pulse_at);
        if (u_if.upd_valid) begin
          wait_cnt++;
          if (exp_q.size() == 0) begin
            chk("upd_extra", 1, 0);
            rdy = 1'b1;
          end else begin
            chk("upd_x", u_if.upd_x, exp_q[0].ux);
            chk("upd_y", u_if.upd_y, exp_q[0].uy);
            chk("upd_code", u_if.upd_code, exp_q[0].code);
            rdy = (wait_cnt > delay);
            if (rdy) begin
              last_x = exp_q[0].ux; last_y = exp_q[0].uy;
              void'(exp_q.pop_front());
            end
          end
          if (rdy) begin got_cnt++; wait_cnt = 0; end
        end else begin
          rdy = 1'($urandom_range(0, 1));
        end
        u_if.upd_ready = rdy;
        @(negedge clk);
        cyc++;
      end
    end
    frame_start = 1'b0;
    u_if.upd_ready = 1'b0;
    chk("frame_done_seen", done, 1);
    chk("upd_count", got_cnt, n_exp);
    chk("upd_missing", exp_q.size(), 0);
    if (len_chk) chk("frame_len", cyc, GW * GH + n_exp + 1);
    chk("x_done", x, 0);
    chk("y_done", y, 0);
    @(negedge clk);
    chk("frame_done_pulse", frame_done, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic reset_model();
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++) prev_m[r][c] = 3'd0;
    init_m = 1'b1;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; frame_start = 1'b0; full_redraw = 1'b0; game_over = 1'b0;
    u_if.upd_ready = 1'b0;
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++)
        map_m[r][c] = (r == 0 || r == GH-1 || c == 0 || c == GW-1) ? 3'd4 : 3'd0;
    reset_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_valid", u_if.upd_valid, 0);
    chk("rst_upd_x", u_if.upd_x, 0);
    chk("rst_upd_y", u_if.upd_y, 0);
    chk("rst_upd_code", u_if.upd_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);

    // Reset while a request is pending.
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cnt = 0;
    while (!u_if.upd_valid && cnt < 50) begin @(negedge clk); cnt++; end
    chk("issue_before_rst", u_if.upd_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", u_if.upd_valid, 0);
    chk("rst_async_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();

    // First frame after reset is a full redraw.
    run_frame(0, 0, 0, -1, 1);
    chk("full_count", got_cnt, 192);
    // Unchanged diff frame.
    run_frame(0, 0, 0, -1, 1);
    chk("quiet_count", got_cnt, 0);
    // Head placed, then moved with body behind it; slow driver.
    map_m[4][4] = 3'd1;
    run_frame(0, 0, 0, -1, 1);
    map_m[4][4] = 3'd2;
    map_m[4][5] = 3'd1;
    run_frame(0, 0, 3, -1, 0);
    chk("move_count", got_cnt, 2);
    chk("move_last_x", last_x, 5);
    // Six apples bring the stored non-empty count to 60, then clear.
    for (int c = 2; c < 8; c++) map_m[8][c] = 3'd3;
    run_frame(0, 0, 0, -1, 1);
    run_frame($urandom_range(0, 1), 1, 0, -1, 1);
    chk("clear_count", got_cnt, 60);
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++) map_m[r][c] = 3'd0;
    run_frame(0, 0, 0, -1, 1);
    chk("after_clear_count", got_cnt, 0);

    // Random map edits, modes and driver latency.
    for (int f = 0; f < 5; f++) begin
      int d;
      for (int k = 0; k < 12; k++)
        map_m[$urandom_range(0, GH-1)][$urandom_range(0, GW-1)] = 3'($urandom_range(0, 4));
      d = $urandom_range(0, 3);
      run_frame(($urandom_range(0, 3) == 0), 0, d, -1, (d == 0));
    end

    // Last cell changed with a stray frame_start during the scan.
    map_m[GH-1][GW-1] = (prev_m[GH-1][GW-1] == 3'd3) ? 3'd2 : 3'd3;
    run_frame(0, 0, 1, 40, 0);
    chk("last_upd_x", last_x, GW-1);
    chk("last_upd_y", last_y, GH-1);
    run_frame(0, 0, 0, -1, 1);
    chk("stray_pulse_quiet", got_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
